knightrider_input_ctrl: RTL and testbench

//  Front end for the LED pattern generator. Conditions the raw board inputs
//  (8 slide switches, 2 active-low push keys) and produces the registered

---
 rtl/knightrider_input_ctrl.sv | 113 +++++++++++
 tb/tb_knightrider_input_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/knightrider_input_ctrl.sv
// Input front end for the LED pattern generator: synchronises and debounces the
// slide switches and push keys, then turns accepted changes into mode/speed writes.
module knightrider_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic [7:0] sw,
  input  logic [1:0] key,
  output logic [3:0] mode,
  output logic [3:0] speed,
  output logic       cfg_stb
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]            sw_s1_q, sw_s1_d;
  logic [7:0]            sw_s2_q, sw_s2_d;
  logic [7:0]            sw_stable_q, sw_stable_d;
  logic [CNT_W-1:0]      sw_cnt_q, sw_cnt_d;
  logic                  sw_commit;

  logic [1:0]            key_s1_q, key_s1_d;
  logic [1:0]            key_s2_q, key_s2_d;
  logic [1:0]            key_stable_q, key_stable_d;
  logic [1:0][CNT_W-1:0] key_cnt_q, key_cnt_d;
  logic [1:0]            key_press;

  logic [3:0]            mode_q, mode_d;
  logic [3:0]            speed_q, speed_d;
  logic                  cfg_stb_q, cfg_stb_d;

  always_comb begin
    sw_s1_d     = sw;
    sw_s2_d     = sw_s1_q;
    key_s1_d    = key;
    key_s2_d    = key_s1_q;

    // Counting only continues while s2 differs from stable and s1 agrees with s2,
    // so any glitch on s1 restarts the count from zero.
    sw_stable_d = sw_stable_q;
    sw_cnt_d    = '0;
    sw_commit   = 1'b0;
    if ((sw_s2_q != sw_stable_q) && (sw_s1_q == sw_s2_q)) begin
      if (sw_cnt_q == CNT_LAST) begin
        sw_commit   = 1'b1;
        sw_stable_d = sw_s2_q;
      end else begin
        sw_cnt_d = sw_cnt_q + CNT_W'(1);
      end
    end

    key_stable_d = key_stable_q;
    key_cnt_d    = '0;
    key_press    = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if ((key_s2_q[i] != key_stable_q[i]) && (key_s1_q[i] == key_s2_q[i])) begin
        if (key_cnt_q[i] == CNT_LAST) begin
          key_stable_d[i] = key_s2_q[i];
          key_press[i]    = ~key_s2_q[i];
        end else begin
          key_cnt_d[i] = key_cnt_q[i] + CNT_W'(1);
        end
      end
    end

    // A switch load fully determines both fields and masks any key step.
    mode_d  = mode_q;
    speed_d = speed_q;
    if (sw_commit) begin
      mode_d  = sw_s2_q[7:4];
      speed_d = sw_s2_q[3:0];
    end else begin
      if (key_press[0]) mode_d  = mode_q + 4'd1;
      if (key_press[1]) speed_d = speed_q + 4'd1;
    end
    cfg_stb_d = sw_commit | (|key_press);
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      sw_s1_q      <= '0;
      sw_s2_q      <= '0;
      sw_stable_q  <= '0;
      sw_cnt_q     <= '0;
      key_s1_q     <= 2'b11;
      key_s2_q     <= 2'b11;
      key_stable_q <= 2'b11;
      key_cnt_q    <= '0;
      mode_q       <= '0;
      speed_q      <= '0;
      cfg_stb_q    <= 1'b0;
    end else begin
      sw_s1_q      <= sw_s1_d;
      sw_s2_q      <= sw_s2_d;
      sw_stable_q  <= sw_stable_d;
      sw_cnt_q     <= sw_cnt_d;
      key_s1_q     <= key_s1_d;
      key_s2_q     <= key_s2_d;
      key_stable_q <= key_stable_d;
      key_cnt_q    <= key_cnt_d;
      mode_q       <= mode_d;
      speed_q      <= speed_d;
      cfg_stb_q    <= cfg_stb_d;
    end
  end

  assign mode    = mode_q;
  assign speed   = speed_q;
  assign cfg_stb = cfg_stb_q;

endmodule

// File: tb/tb_knightrider_input_ctrl.sv
// Directed bench for knightrider_input_ctrl with a short debounce window; every
// edge after a stimulus change is checked against hand-computed mode/speed/strobe.
module tb_knightrider_input_ctrl;

  localparam int DEB = 4;

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sw    = 8'h00;
  logic [1:0] key   = 2'b11;
  logic [3:0] mode;
  logic [3:0] speed;
  logic       cfg_stb;

  int vectors     = 0;
  int miscompares = 0;

  knightrider_input_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (3)
  ) dut (
    .clkin  (clkin),
    .reset  (reset),
    .sw     (sw),
    .key    (key),
    .mode   (mode),
    .speed  (speed),
    .cfg_stb(cfg_stb)
  );

  always #5 clkin = ~clkin;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge, so the next rising edge is "edge 1".
  task automatic applyStimulus(input logic [7:0] sw_val, input logic [1:0] key_val);
    @(negedge clkin);
    sw  = sw_val;
    key = key_val;
  endtask

  // stb_edge == 0 means no strobe is expected in this window.
  task automatic expectEdges(input int n, input int stb_edge,
                             input logic [3:0] m_before, input logic [3:0] s_before,
                             input logic [3:0] m_after,  input logic [3:0] s_after);
    for (int i = 1; i <= n; i++) begin
      logic after;
      @(posedge clkin);
      #1;
      after = (stb_edge != 0) && (i >= stb_edge);
      checkOutput($sformatf("stb@%0d", i), {7'b0, cfg_stb}, {7'b0, (i == stb_edge)});
      checkOutput($sformatf("mode@%0d", i), {4'b0, mode}, {4'b0, after ? m_after : m_before});
      checkOutput($sformatf("speed@%0d", i), {4'b0, speed}, {4'b0, after ? s_after : s_before});
    end
  endtask

  initial begin
    $display("[TB] start, DEBOUNCE_CYCLES=%0d", DEB);

    // 1: reset then idle inputs, nothing may change
    repeat (2) @(posedge clkin);
    @(negedge clkin);
    reset = 1'b0;
    expectEdges(20, 0, 4'h0, 4'h0, 4'h0, 4'h0);

    // 2: switch load at edge DEB+2, then a short pulse that must be ignored
    applyStimulus(8'hA3, 2'b11);
    expectEdges(8, DEB + 2, 4'h0, 4'h0, 4'hA, 4'h3);
    applyStimulus(8'h5F, 2'b11);
    expectEdges(3, 0, 4'hA, 4'h3, 4'hA, 4'h3);
    applyStimulus(8'hA3, 2'b11);
    expectEdges(10, 0, 4'hA, 4'h3, 4'hA, 4'h3);

    // 3: mode wraps from F to 0 on a held key; release gives no event
    applyStimulus(8'hF3, 2'b11);
    expectEdges(8, DEB + 2, 4'hA, 4'h3, 4'hF, 4'h3);
    applyStimulus(8'hF3, 2'b10);
    expectEdges(10, DEB + 2, 4'hF, 4'h3, 4'h0, 4'h3);
    applyStimulus(8'hF3, 2'b11);
    expectEdges(10, 0, 4'h0, 4'h3, 4'h0, 4'h3);

    // 4: both keys together from mode=2, speed=F
    applyStimulus(8'h2F, 2'b11);
    expectEdges(8, DEB + 2, 4'h0, 4'h3, 4'h2, 4'hF);
    applyStimulus(8'h2F, 2'b00);
    expectEdges(8, DEB + 2, 4'h2, 4'hF, 4'h3, 4'h0);
    applyStimulus(8'h2F, 2'b11);
    expectEdges(8, 0, 4'h3, 4'h0, 4'h3, 4'h0);

    // 5: switch load and key[1] press on the same edge; the load wins
    applyStimulus(8'h71, 2'b01);
    expectEdges(8, DEB + 2, 4'h3, 4'h0, 4'h7, 4'h1);
    applyStimulus(8'h71, 2'b11);
    expectEdges(8, 0, 4'h7, 4'h1, 4'h7, 4'h1);

    // 6: reset mid-count discards progress; load re-fires DEB+2 edges after release
    applyStimulus(8'hC5, 2'b11);
    expectEdges(2, 0, 4'h7, 4'h1, 4'h7, 4'h1);
    @(negedge clkin);
    reset = 1'b1;
    @(posedge clkin);
    #1;
    checkOutput("rst_mode", {4'b0, mode}, 8'h00);
    checkOutput("rst_speed", {4'b0, speed}, 8'h00);
    checkOutput("rst_stb", {7'b0, cfg_stb}, 8'h00);
    @(posedge clkin);
    @(negedge clkin);
    reset = 1'b0;
    expectEdges(8, DEB + 2, 4'h0, 4'h0, 4'hC, 4'h5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
